// File: rtl/inst_exec_block.sv
// rtl/inst_exec_block.sv - multicycle decode/execute/writeback datapath driven by the fetch block's phase code
// Optional macro INST_EXEC_DBG_EN adds a combinational register-file debug read port.
module inst_exec_block #(
    parameter int ZERO_R0 = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  ESTADO,
    input  logic [31:0] IR,
    input  logic [15:0] NPC,
`ifdef INST_EXEC_DBG_EN
    input  logic [2:0]  DBG_ADDR,
    output logic [15:0] DBG_DATA,
`endif
    output logic [15:0] ULA,
    output logic        COND,
    output logic        SEQ_ERR
);

    localparam logic [2:0] PH_IF  = 3'd0;
    localparam logic [2:0] PH_ID  = 3'd1;
    localparam logic [2:0] PH_EX  = 3'd2;
    localparam logic [2:0] PH_MEM = 3'd3;
    localparam logic [2:0] PH_WB  = 3'd4;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_BEQZ = 6'd6;
    localparam logic [5:0] OP_BNEZ = 6'd7;
    localparam logic [5:0] OP_J    = 6'd8;

    logic [15:0] regs [8];
    logic [2:0]  phase;
    logic [5:0]  op_q;
    logic [2:0]  rt_q;
    logic [2:0]  rd_q;
    logic [15:0] imm_q;
    logic [15:0] npc_q;
    logic [15:0] a_q;
    logic [15:0] b_q;

    logic [15:0] rs_val;
    logic [15:0] rt_val;
    logic [15:0] ex_ula;
    logic        ex_cond;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic        unused_ir;

    // Reserved IR bits between the register fields carry no meaning
    assign unused_ir = ^{IR[25:24], IR[20:19], PH_MEM};

    always_comb begin
        rs_val = regs[IR[23:21]];
        rt_val = regs[IR[18:16]];
        if (ZERO_R0 != 0 && IR[23:21] == 3'd0) rs_val = 16'd0;
        if (ZERO_R0 != 0 && IR[18:16] == 3'd0) rt_val = 16'd0;
    end

    always_comb begin
        ex_ula  = ULA;
        ex_cond = 1'b0;
        case (op_q)
            OP_ADD:  ex_ula = a_q + b_q;
            OP_SUB:  ex_ula = a_q - b_q;
            OP_AND:  ex_ula = a_q & b_q;
            OP_OR:   ex_ula = a_q | b_q;
            OP_ADDI: ex_ula = a_q + imm_q;
            OP_BEQZ: begin
                ex_ula  = npc_q + imm_q;
                ex_cond = (a_q == 16'd0);
            end
            OP_BNEZ: begin
                ex_ula  = npc_q + imm_q;
                ex_cond = (a_q != 16'd0);
            end
            OP_J: begin
                ex_ula  = npc_q + imm_q;
                ex_cond = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_en   = 1'b0;
        wb_addr = rd_q;
        if (op_q >= OP_ADD && op_q <= OP_OR) begin
            wb_en = 1'b1;
        end else if (op_q == OP_ADDI) begin
            wb_en   = 1'b1;
            wb_addr = rt_q;
        end
        if (ZERO_R0 != 0 && wb_addr == 3'd0) wb_en = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase   <= PH_IF;
            SEQ_ERR <= 1'b0;
            ULA     <= 16'd0;
            COND    <= 1'b0;
            op_q    <= 6'd0;
            rt_q    <= 3'd0;
            rd_q    <= 3'd0;
            imm_q   <= 16'd0;
            npc_q   <= 16'd0;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else if (ESTADO > PH_WB) begin
            SEQ_ERR <= 1'b1;
            phase   <= PH_IF;
        end else begin
            if (ESTADO != phase) SEQ_ERR <= 1'b1;
            // Tracker follows whatever phase arrived, so a single glitch flags once
            phase <= (ESTADO == PH_WB) ? PH_IF : ESTADO + 3'd1;
            case (ESTADO)
                PH_ID: begin
                    op_q  <= IR[31:26];
                    rt_q  <= IR[18:16];
                    rd_q  <= IR[13:11];
                    imm_q <= IR[15:0];
                    npc_q <= NPC;
                    a_q   <= rs_val;
                    b_q   <= rt_val;
                    COND  <= 1'b0;
                end
                PH_EX: begin
                    ULA  <= ex_ula;
                    COND <= ex_cond;
                end
                PH_WB: if (wb_en) regs[wb_addr] <= ULA;
                default: ;
            endcase
        end
    end

`ifdef INST_EXEC_DBG_EN
    assign DBG_DATA = (ZERO_R0 != 0 && DBG_ADDR == 3'd0) ? 16'd0 : regs[DBG_ADDR];
`endif

endmodule
